// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - size codes, FSM states and address helpers for the load/store unit
package mem_lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   // Size code 2'b11 is handled as a word everywhere.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic mis;
      case (size)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = lane[0];
         default: mis = |lane;
      endcase
      return mis;
   endfunction

   function automatic logic [31:0] align_down(input logic [1:0] size, input logic [31:0] addr);
      logic [31:0] a;
      case (size)
         SZ_B:    a = addr;
         SZ_H:    a = {addr[31:1], 1'b0};
         default: a = {addr[31:2], 2'b00};
      endcase
      return a;
   endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - request/response and data-RAM signal bundle of the load/store unit
interface mem_lsu_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic        ram_we;
   logic [31:0] ram_waddr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_raddr;
   logic [31:0] ram_rdata;

   // master: MEM stage plus RAM model; slave: the load/store unit
   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output rsp_ready, ram_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  ram_we, ram_waddr, ram_wdata, ram_raddr
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  rsp_ready, ram_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output ram_we, ram_waddr, ram_wdata, ram_raddr
   );

endinterface

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - combinational lane extract/extend and lane merge for one RAM word
module mem_lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] wdata,
   output logic [31:0] ext_data,
   output logic [31:0] merged_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = 8'h00;
      case (lane)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
      half_v = lane[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      ext_data = word;
      case (size)
         SZ_B:    ext_data = {{24{sign & byte_v[7]}}, byte_v};
         SZ_H:    ext_data = {{16{sign & half_v[15]}}, half_v};
         default: ext_data = word;
      endcase
   end

   always_comb begin
      merged_data = word;
      case (size)
         SZ_B: begin
            case (lane)
               2'd0:    merged_data[7:0]   = wdata[7:0];
               2'd1:    merged_data[15:8]  = wdata[7:0];
               2'd2:    merged_data[23:16] = wdata[7:0];
               default: merged_data[31:24] = wdata[7:0];
            endcase
         end
         SZ_H: begin
            if (lane[1]) merged_data[31:16] = wdata[15:0];
            else         merged_data[15:0]  = wdata[15:0];
         end
         default: merged_data = wdata;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit between the MEM stage and the word-only data RAM
// Build option MEM_LSU_MISALIGN_EXC_EN: misaligned accesses fault instead of aligning down.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int RAM_AW = 12
) (
   input  logic     clk,
   input  logic     rst,
   mem_lsu_if.slave bus
);

   state_t      state, state_nx;
   logic [31:0] addr_q, wdata_q, word_q, rdata_q;
   logic [1:0]  size_q;
   logic        signed_q, err_q;

   logic [31:0] addr_in, load_ext, merged;
   logic [31:0] load_merge_unused, merge_ext_unused;
   logic        range_fault, align_fault, fault, accept;

   logic        req_ready_c, rsp_valid_c, rsp_err_c, ram_we_c;
   logic [31:0] rsp_rdata_c, ram_waddr_c, ram_wdata_c, ram_raddr_c;

   assign range_fault = |bus.req_addr[31:RAM_AW+2];
`ifdef MEM_LSU_MISALIGN_EXC_EN
   assign align_fault = is_misaligned(bus.req_size, bus.req_addr[1:0]);
   assign addr_in     = bus.req_addr;
`else
   assign align_fault = 1'b0;
   assign addr_in     = align_down(bus.req_size, bus.req_addr);
`endif
   assign fault  = range_fault | align_fault;
   assign accept = bus.req_valid & (state == ST_IDLE);

   // Both instances look at the same RAM word; only one is meaningful per state.
   mem_lsu_align u_load (
      .word        (bus.ram_rdata),
      .lane        (addr_q[1:0]),
      .size        (size_q),
      .sign        (signed_q),
      .wdata       (32'h0),
      .ext_data    (load_ext),
      .merged_data (load_merge_unused)
   );

   mem_lsu_align u_merge (
      .word        (bus.ram_rdata),
      .lane        (addr_q[1:0]),
      .size        (size_q),
      .sign        (1'b0),
      .wdata       (wdata_q),
      .ext_data    (merge_ext_unused),
      .merged_data (merged)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      req_ready_c = 1'b0;
      rsp_valid_c = 1'b0;
      rsp_rdata_c = 32'h0;
      rsp_err_c   = 1'b0;
      ram_we_c    = 1'b0;
      ram_waddr_c = 32'h0;
      ram_wdata_c = 32'h0;
      ram_raddr_c = 32'h0;
      case (state)
         ST_IDLE: begin
            req_ready_c = 1'b1;
            if (bus.req_valid) begin
               if (fault)              state_nx = ST_RESP;
               else if (!bus.req_we)   state_nx = ST_LOAD;
               else if (bus.req_size[1]) state_nx = ST_WRITE;
               else                    state_nx = ST_MERGE;
            end
         end
         ST_LOAD: begin
            ram_raddr_c = {2'b00, addr_q[31:2]};
            state_nx    = ST_RESP;
         end
         ST_MERGE: begin
            ram_raddr_c = {2'b00, addr_q[31:2]};
            state_nx    = ST_WRITE;
         end
         ST_WRITE: begin
            ram_we_c    = 1'b1;
            ram_waddr_c = {2'b00, addr_q[31:2]};
            ram_wdata_c = word_q;
            state_nx    = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid_c = 1'b1;
            rsp_rdata_c = rdata_q;
            rsp_err_c   = err_q;
            if (bus.rsp_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Request capture and per-state datapath; rdata_q stays 0 for stores and faults.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         word_q   <= 32'h0;
         rdata_q  <= 32'h0;
         size_q   <= SZ_B;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  addr_q   <= addr_in;
                  wdata_q  <= bus.req_wdata;
                  word_q   <= bus.req_wdata;
                  size_q   <= bus.req_size;
                  signed_q <= bus.req_signed;
                  err_q    <= fault;
                  rdata_q  <= 32'h0;
               end
            end
            ST_LOAD:  rdata_q <= load_ext;
            ST_MERGE: word_q  <= merged;
            default: ;
         endcase
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_rdata = rsp_rdata_c;
   assign bus.rsp_err   = rsp_err_c;
   assign bus.ram_we    = ram_we_c;
   assign bus.ram_waddr = ram_waddr_c;
   assign bus.ram_wdata = ram_wdata_c;
   assign bus.ram_raddr = ram_raddr_c;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - self-checking bench for mem_lsu against a behavioural byte-lane model
module tb_mem_lsu;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_lsu_if bus ();

   mem_lsu #(.RAM_AW(12)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] ram       [0:4095];
   logic [31:0] model_mem [0:4095];
   logic        pre_we = 1'b0;
   logic [11:0] pre_idx = 12'h0;
   logic [31:0] pre_data = 32'h0;
   int          we_count = 0;

   assign bus.ram_rdata = ram[bus.ram_raddr[11:0]];

   always @(posedge clk) begin
      if (pre_we)          ram[pre_idx] <= pre_data;
      else if (bus.ram_we) ram[bus.ram_waddr[11:0]] <= bus.ram_wdata;
      if (bus.ram_we) we_count <= we_count + 1;
   end

   task automatic preload(input logic [11:0] idx, input logic [31:0] data);
      @(negedge clk);
      pre_we = 1'b1; pre_idx = idx; pre_data = data;
      @(negedge clk);
      pre_we = 1'b0;
      model_mem[idx] = data;
   endtask

   // Reference: byte-addressed memory semantics on a 16 KiB space of 32-bit words.
   task automatic model_access(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat);
      int          nbytes, shift;
      logic [31:0] ea, mask, word, val, lowbits;
      nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      mask    = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      lowbits = 32'(nbytes) - 32'd1;
      rdata   = 32'h0;
`ifdef MEM_LSU_MISALIGN_EXC_EN
      err = (addr & lowbits) != 32'h0;
      ea  = addr;
`else
      err = 1'b0;
      ea  = addr & ~lowbits;
`endif
      if (addr >= 32'h0000_4000) err = 1'b1;
      if (err) begin
         lat = 1;
         return;
      end
      word  = model_mem[ea[13:2]];
      shift = 8 * int'(ea[1:0]);
      if (!we) begin
         val = (word >> shift) & mask;
         if (sgn && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
         rdata = val;
         lat   = 2;
      end else begin
         model_mem[ea[13:2]] = (word & ~(mask << shift)) | ((wdata & mask) << shift);
         lat = (nbytes == 4) ? 2 : 3;
      end
   endtask

   task automatic run_req(input string name, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input int delay, input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat);
      int cyc, we0, exp_we;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
      bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s idle_req_ready: got %b want 1", name, bus.req_ready);
      end
      we0 = we_count;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      cyc = 1;
      while (bus.rsp_valid !== 1'b1 && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
      end
      exp_we = (we && !exp_err) ? 1 : 0;
      checks++;
      if (we_count - we0 != exp_we) begin
         errors++;
         $display("FAIL %s write_pulses: got %0d want %0d", name, we_count - we0, exp_we);
      end
      for (int i = 0; i <= delay; i++) begin
         checks++;
         if ({bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, exp_err, exp_rdata}) begin
            errors++;
            $display("FAIL %s rsp[%0d]: got valid=%b ready=%b err=%b rdata=%h want valid=1 ready=0 err=%b rdata=%h",
                     name, i, bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_rdata, exp_err, exp_rdata);
         end
         if (i < delay) @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      checks++;
      if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL %s handoff: got valid=%b ready=%b want valid=0 ready=1", name, bus.rsp_valid, bus.req_ready);
      end
      if (we && !exp_err) begin
         checks++;
         if (ram[addr[13:2]] !== model_mem[addr[13:2]]) begin
            errors++;
            $display("FAIL %s ram_word: got %h want %h", name, ram[addr[13:2]], model_mem[addr[13:2]]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.ram_we} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctrl: got ready=%b valid=%b err=%b we=%b want 1 0 0 0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.ram_we);
      end
      checks++;
      if ({bus.rsp_rdata, bus.ram_waddr, bus.ram_wdata, bus.ram_raddr} !== 128'h0) begin
         errors++;
         $display("FAIL reset_data: got rdata=%h waddr=%h wdata=%h raddr=%h want all 0",
                  bus.rsp_rdata, bus.ram_waddr, bus.ram_wdata, bus.ram_raddr);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_load();
      preload(12'd1, 32'h0000_5678);
      preload(12'd2, 32'h80FF_1234);
      run_req("lw_4",   1'b0, 2'b10, 1'b1, 32'h4, 32'h0, 0, 32'h0000_5678, 1'b0, 2);
      run_req("lb_9",   1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 0, 32'h0000_0012, 1'b0, 2);
      run_req("lbu_a",  1'b0, 2'b00, 1'b0, 32'hA, 32'h0, 0, 32'h0000_00FF, 1'b0, 2);
      run_req("lh_a",   1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 0, 32'hFFFF_80FF, 1'b0, 2);
      run_req("lhu_a",  1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 0, 32'h0000_80FF, 1'b0, 2);
   endtask

   task automatic test_store();
      logic [31:0] r; logic e; int l;
      model_access(1'b1, 2'b00, 1'b0, 32'h8, 32'h0000_00AB, r, e, l);
      run_req("sb_8", 1'b1, 2'b00, 1'b0, 32'h8, 32'h0000_00AB, 0, 32'h0, 1'b0, 3);
      checks++;
      if (ram[2] !== 32'h80FF_12AB) begin
         errors++;
         $display("FAIL sb_8_word2: got %h want 80ff12ab", ram[2]);
      end
      model_access(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000_CDEF, r, e, l);
      run_req("sh_a", 1'b1, 2'b01, 1'b0, 32'hA, 32'h0000_CDEF, 0, 32'h0, 1'b0, 3);
      checks++;
      if (ram[2] !== 32'hCDEF_12AB) begin
         errors++;
         $display("FAIL sh_a_word2: got %h want cdef12ab", ram[2]);
      end
   endtask

   task automatic test_fault();
      run_req("sw_oob",    1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 0, 32'h0, 1'b1, 1);
      run_req("lb_oob_hi", 1'b0, 2'b00, 1'b1, 32'hFFFF_FFF0, 32'h0, 1, 32'h0, 1'b1, 1);
   endtask

   task automatic test_misalign();
`ifdef MEM_LSU_MISALIGN_EXC_EN
      run_req("lw_6_mis", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 0, 32'h0, 1'b1, 1);
`else
      run_req("lw_6_mis", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 0, 32'h0000_5678, 1'b0, 2);
`endif
   endtask

   task automatic test_backpressure();
      run_req("lh_stall", 1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 5, 32'hFFFF_CDEF, 1'b0, 2);
   endtask

   task automatic test_reset_merge();
      int we0;
      logic [31:0] r; logic e; int l;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
      bus.req_signed = 1'b0; bus.req_addr = 32'h8; bus.req_wdata = 32'h55;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      we0 = we_count;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.ram_we, bus.rsp_rdata, bus.ram_waddr, bus.ram_wdata, bus.ram_raddr}
          !== {4'b1000, 128'h0}) begin
         errors++;
         $display("FAIL reset_in_merge: got ready=%b valid=%b err=%b we=%b raddr=%h want 1 0 0 0 0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.ram_we, bus.ram_raddr);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (we_count != we0) begin
         errors++;
         $display("FAIL reset_in_merge_we: got %0d pulses want 0", we_count - we0);
      end
      model_access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, r, e, l);
      run_req("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, r, e, l);
   endtask

   task automatic test_random();
      logic        we, sgn, e;
      logic [1:0]  size;
      logic [31:0] addr, wdata, r;
      int          l;
      for (int i = 0; i < 16; i++) preload(12'(i), $urandom);
      for (int n = 0; n < 80; n++) begin
         we    = 1'($urandom_range(0, 1));
         sgn   = 1'($urandom_range(0, 1));
         size  = 2'($urandom_range(0, 3));
         wdata = $urandom;
         if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_4000;
         else addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         model_access(we, size, sgn, addr, wdata, r, e, l);
         run_req($sformatf("rand%0d", n), we, size, sgn, addr, wdata, $urandom_range(0, 2), r, e, l);
      end
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
      bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
      test_reset();
      test_load();
      test_store();
      test_fault();
      test_misalign();
      test_backpressure();
      test_reset_merge();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
